// File: rtl/axi_defs_pkg.sv
// Shared AXI encodings, FSM state type and response helpers for the burst memory slave.
package axi_defs_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} axiState_e;

  // Only INCR and FIXED with beats no wider than the 64-bit bus are served.
  function automatic logic isErrBurst(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'b11) || (size > 3'd3);
  endfunction

  function automatic logic [1:0] beatResp(input logic errBurst, input logic decErr);
    return decErr ? RESP_DECERR : (errBurst ? RESP_SLVERR : RESP_OKAY);
  endfunction

  // DECERR outranks SLVERR, which outranks OKAY.
  function automatic logic [1:0] worstResp(input logic [1:0] a, input logic [1:0] b);
    if ((a == RESP_DECERR) || (b == RESP_DECERR)) return RESP_DECERR;
    if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port 64-bit word RAM with byte-enable write and registered read.
module axi_mem_ram #(
  parameter int C_WORDS = 1024,
  parameter int IDX_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [63:0]      i_wdata,
  input  logic [7:0]       i_wstrb,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [63:0]      o_rdata
);

  logic [63:0] r_mem [C_WORDS];
  logic [63:0] r_rdata;

  // No reset so the array maps onto block RAM; the read register only loads on i_re.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave serving one transaction at a time from a 64-bit word RAM.
// Unsupported bursts answer SLVERR; beats above the top of memory answer DECERR.
module axi_burst_mem_slave
  import axi_defs_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 5,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_MEM_WORDS        = 1024
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awlock,
  input  logic [3:0]                      s_axi_awcache,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [3:0]                      s_axi_awqos,
  input  logic [3:0]                      s_axi_awregion,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arlock,
  input  logic [3:0]                      s_axi_arcache,
  input  logic [2:0]                      s_axi_arprot,
  input  logic [3:0]                      s_axi_arqos,
  input  logic [3:0]                      s_axi_arregion,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W = $clog2(C_MEM_WORDS);
  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(8 * C_MEM_WORDS);

  function automatic logic isDecErr(input logic [AW-1:0] addr);
    return {1'b0, addr} >= ADDR_LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] wordIdx(input logic [AW-1:0] addr);
    return IDX_W'(addr >> 3);
  endfunction

  axiState_e                   r_state;
  logic                        r_lastWasWrite;
  logic [C_S_AXI_ID_WIDTH-1:0] r_id;
  logic [AW-1:0]               r_addr;
  logic [7:0]                  r_len;
  logic [7:0]                  r_cnt;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst;
  logic                        r_errBurst;
  logic [1:0]                  r_wResp;
  logic [1:0]                  r_bresp;
  logic                        r_bvalid;
  logic [1:0]                  r_rresp;
  logic                        r_rvalid;
  logic                        r_rlast;
  logic                        r_rzero;

  logic             w_idle;
  logic             w_preferWrite;
  logic             w_awHs;
  logic             w_arHs;
  logic             w_wBeat;
  logic             w_lastBeat;
  logic             w_wDec;
  logic [1:0]       w_wRespAcc;
  logic             w_arErr;
  logic             w_arDec;
  logic [1:0]       w_arResp;
  logic [AW-1:0]    w_nextAddr;
  logic             w_nextDec;
  logic [1:0]       w_nextResp;
  logic             w_rAdvance;
  logic             w_ramWe;
  logic             w_ramRe;
  logic [IDX_W-1:0] w_ramWaddr;
  logic [IDX_W-1:0] w_ramRaddr;
  logic [63:0]      w_ramRdata;
  logic             w_unused;

  // Readies are gated so only the arbitration winner sees a handshake when both are valid.
  assign w_idle        = (r_state == IDLE);
  assign w_preferWrite = !r_lastWasWrite;
  assign s_axi_awready = w_idle && (!s_axi_arvalid || w_preferWrite);
  assign s_axi_arready = w_idle && (!s_axi_awvalid || !w_preferWrite);
  assign w_awHs        = s_axi_awvalid && s_axi_awready;
  assign w_arHs        = s_axi_arvalid && s_axi_arready;

  assign w_nextAddr = (r_burst == BURST_FIXED) ? r_addr : r_addr + (AW'(1) << r_size);

  assign w_wBeat    = s_axi_wvalid && s_axi_wready;
  assign w_lastBeat = (r_cnt == r_len);
  assign w_wDec     = isDecErr(r_addr);
  assign w_wRespAcc = worstResp(r_wResp,
                        beatResp(r_errBurst || (s_axi_wlast != w_lastBeat), w_wDec));

  assign w_arErr    = isErrBurst(s_axi_arburst, s_axi_arsize);
  assign w_arDec    = isDecErr(s_axi_araddr);
  assign w_arResp   = beatResp(w_arErr, w_arDec);
  assign w_nextDec  = isDecErr(w_nextAddr);
  assign w_nextResp = beatResp(r_errBurst, w_nextDec);
  assign w_rAdvance = (r_state == RDATA) && s_axi_rready && !r_rlast;

  // The first read beat is fetched straight from araddr so rvalid can rise right after AR.
  assign w_ramWe    = w_wBeat && !r_errBurst && !w_wDec;
  assign w_ramWaddr = wordIdx(r_addr);
  assign w_ramRe    = w_arHs || w_rAdvance;
  assign w_ramRaddr = w_arHs ? wordIdx(s_axi_araddr) : wordIdx(w_nextAddr);

  axi_mem_ram #(
    .C_WORDS (C_MEM_WORDS),
    .IDX_W   (IDX_W)
  ) u_ram (
    .i_clk   (s_axi_aclk),
    .i_we    (w_ramWe),
    .i_waddr (w_ramWaddr),
    .i_wdata (s_axi_wdata),
    .i_wstrb (s_axi_wstrb),
    .i_re    (w_ramRe),
    .i_raddr (w_ramRaddr),
    .o_rdata (w_ramRdata)
  );

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state        <= IDLE;
      r_lastWasWrite <= 1'b0;
      r_id           <= '0;
      r_addr         <= '0;
      r_len          <= '0;
      r_cnt          <= '0;
      r_size         <= '0;
      r_burst        <= '0;
      r_errBurst     <= 1'b0;
      r_wResp        <= RESP_OKAY;
      r_bresp        <= RESP_OKAY;
      r_bvalid       <= 1'b0;
      r_rresp        <= RESP_OKAY;
      r_rvalid       <= 1'b0;
      r_rlast        <= 1'b0;
      r_rzero        <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_awHs) begin
            r_id           <= s_axi_awid;
            r_addr         <= s_axi_awaddr;
            r_len          <= s_axi_awlen;
            r_size         <= s_axi_awsize;
            r_burst        <= s_axi_awburst;
            r_cnt          <= '0;
            r_errBurst     <= isErrBurst(s_axi_awburst, s_axi_awsize);
            r_wResp        <= RESP_OKAY;
            r_lastWasWrite <= 1'b1;
            r_state        <= WDATA;
          end else if (w_arHs) begin
            r_id           <= s_axi_arid;
            r_addr         <= s_axi_araddr;
            r_len          <= s_axi_arlen;
            r_size         <= s_axi_arsize;
            r_burst        <= s_axi_arburst;
            r_cnt          <= '0;
            r_errBurst     <= w_arErr;
            r_lastWasWrite <= 1'b0;
            r_rvalid       <= 1'b1;
            r_rlast        <= (s_axi_arlen == 8'd0);
            r_rresp        <= w_arResp;
            r_rzero        <= w_arErr || w_arDec;
            r_state        <= RDATA;
          end
        end
        WDATA: begin
          if (w_wBeat) begin
            r_wResp <= w_wRespAcc;
            if (w_lastBeat) begin
              r_bresp  <= w_wRespAcc;
              r_bvalid <= 1'b1;
              r_state  <= WRESP;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_addr <= w_nextAddr;
            end
          end
        end
        WRESP: begin
          if (s_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RDATA: begin
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_addr  <= w_nextAddr;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
              r_rresp <= w_nextResp;
              r_rzero <= r_errBurst || w_nextDec;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axi_wready = (r_state == WDATA);
  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_bid    = r_id;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rlast  = r_rlast;
  assign s_axi_rid    = r_id;
  assign s_axi_rdata  = (r_rvalid && !r_rzero) ? w_ramRdata : '0;

  assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule
